// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller.
// Holds state/op encodings, counter width and default timeout.
package mem_ctrl_pkg;

  localparam int CNT_W       = 8;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for the memory access timeout.
// Ports: clk, i_clr (sync reset), i_clear, i_en, o_tc (terminal count).
module mem_timeout_cnt
  import mem_ctrl_pkg::*;
#(
  parameter int TC = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // High during the TC-th consecutive wait cycle.
  assign o_tc = (r_cnt == CNT_W'(TC - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: sequences MAR/MDR loads and memory strobes.
// Ports: clk, clr (sync high), req_rd/req_wr, mem_ready in;
// mar_en, mdr_en, mdr_read, mem_rd, mem_wr, busy, done, err out.
// Optional timeout abort enabled by macro MEM_TIMEOUT_EN.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic req_rd,
  input  logic req_wr,
  input  logic mem_ready,
  output logic mar_en,
  output logic mdr_en,
  output logic mdr_read,
  output logic mem_rd,
  output logic mem_wr,
  output logic busy,
  output logic done,
  output logic err
);

  state_t r_state;
  state_t w_next;
  op_t    r_op;
  op_t    w_op_next;

`ifdef MEM_TIMEOUT_EN
  logic w_tc;
  logic w_wait;

  assign w_wait = ((r_state == MEM_RD) ||
                   (r_state == MEM_WR)) && !mem_ready;

  mem_timeout_cnt #(
    .TC(TIMEOUT_CYCLES)
  ) u_cnt (
    .clk    (clk),
    .i_clr  (clr),
    .i_clear(r_state == ADDR),
    .i_en   (w_wait),
    .o_tc   (w_tc)
  );
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_op    <= OP_RD;
    end else begin
      r_state <= w_next;
      r_op    <= w_op_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_op_next = r_op;
    mar_en    = 1'b0;
    mdr_en    = 1'b0;
    mdr_read  = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_rd) begin
          w_next    = ADDR;
          w_op_next = OP_RD;
        end else if (req_wr) begin
          w_next    = ADDR;
          w_op_next = OP_WR;
        end
      end
      ADDR: begin
        mar_en = 1'b1;
        busy   = 1'b1;
        if (r_op == OP_WR) begin
          mdr_en = 1'b1;
          w_next = MEM_WR;
        end else begin
          w_next = MEM_RD;
        end
      end
      MEM_RD: begin
        mem_rd   = 1'b1;
        mdr_read = 1'b1;
        busy     = 1'b1;
        mdr_en   = mem_ready;
        if (mem_ready) begin
          w_next = DONE;
`ifdef MEM_TIMEOUT_EN
        end else if (w_tc) begin
          w_next = ERR;
`endif
        end
      end
      MEM_WR: begin
        mem_wr = 1'b1;
        busy   = 1'b1;
        if (mem_ready) begin
          w_next = DONE;
`ifdef MEM_TIMEOUT_EN
        end else if (w_tc) begin
          w_next = ERR;
`endif
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      ERR: begin
`ifdef MEM_TIMEOUT_EN
        done = 1'b1;
        err  = 1'b1;
`endif
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // A reset edge must not load MAR/MDR.
    if (clr) begin
      mar_en = 1'b0;
      mdr_en = 1'b0;
    end
  end

endmodule
